// File: rtl/counter_mod_step.sv
// counter_mod_step: up/down modulo counter with variable step, load and wrap/saturate
module counter_mod_step #(
   parameter int width_p      = 4,
   parameter int max_val_p    = 2**width_p-1,
   parameter int reset_val_p  = 0,
   parameter int step_width_p = 1,
   parameter bit saturate_p   = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    en_i,
   input  logic                    up_i,
   input  logic                    down_i,
   input  logic [step_width_p-1:0] step_i,
   input  logic                    load_i,
   input  logic [width_p-1:0]      load_val_i,
   output logic [width_p-1:0]      count_o,
   output logic                    ovf_o,
   output logic                    unf_o,
   output logic                    at_max_o,
   output logic                    at_min_o
);
   localparam logic [width_p:0]   lp_max = (width_p+1)'(max_val_p);
   localparam logic [width_p:0]   lp_mod = lp_max + (width_p+1)'(1);
   localparam logic [width_p-1:0] lp_rst = width_p'(reset_val_p);
   if (width_p < 1) begin : g_bad_width
      $error("counter_mod_step: width_p must be >= 1");
   end
   if (max_val_p < 1 || max_val_p > 2**width_p-1) begin : g_bad_max
      $error("counter_mod_step: max_val_p out of range");
   end
   if (reset_val_p < 0 || reset_val_p > max_val_p) begin : g_bad_reset
      $error("counter_mod_step: reset_val_p must be within [0, max_val_p]");
   end
   if (step_width_p < 1 || 2**step_width_p-1 > max_val_p) begin : g_bad_step
      $error("counter_mod_step: step range exceeds max_val_p");
   end
   logic [width_p-1:0] r_count;
   logic               r_ovf;
   logic               r_unf;
   logic [width_p:0]   w_cur;
   logic [width_p:0]   w_step;
   logic [width_p:0]   w_sum;
   logic               w_up_cross;
   logic               w_dn_cross;
   logic [width_p-1:0] w_up_val;
   logic [width_p-1:0] w_dn_val;
   logic [width_p-1:0] w_load_val;
   logic [width_p-1:0] w_next;
   logic               w_ovf;
   logic               w_unf;
   logic               w_move;
   // Candidate results computed one bit wider so sums and wrap offsets never truncate
   always_comb begin
      w_cur      = {1'b0, r_count};
      w_step     = (width_p+1)'(step_i);
      w_sum      = w_cur + w_step;
      w_up_cross = w_sum > lp_max;
      w_dn_cross = w_step > w_cur;
      w_up_val   = width_p'(w_up_cross ? (saturate_p ? lp_max : w_sum - lp_mod) : w_sum);
      w_dn_val   = width_p'(w_dn_cross ? (saturate_p ? '0 : w_cur + lp_mod - w_step) : w_cur - w_step);
      w_load_val = width_p'(({1'b0, load_val_i} > lp_max) ? lp_max : {1'b0, load_val_i});
      w_move     = en_i & (up_i ^ down_i) & ~load_i;
      w_next     = load_i ? w_load_val : (w_move ? (up_i ? w_up_val : w_dn_val) : r_count);
      w_ovf      = w_move & up_i & w_up_cross;
      w_unf      = w_move & down_i & w_dn_cross;
   end
   // Count and crossing pulses register together so a pulse lines up with its count
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count <= lp_rst;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_ovf   <= w_ovf;
         r_unf   <= w_unf;
      end
   end
   assign count_o  = r_count;
   assign ovf_o    = r_ovf;
   assign unf_o    = r_unf;
   assign at_max_o = {1'b0, r_count} == lp_max;
   assign at_min_o = r_count == '0;
endmodule

// File: tb/tb_counter_mod_step.sv
// tb_counter_mod_step: directed and model-checked bench for counter_mod_step in four configurations
module tb_counter_mod_step;
   logic       clk = 1'b0;
   logic       rst, en, up, dn, ld;
   logic [1:0] step;
   logic [3:0] ldv;
   logic [3:0] cnt [4];
   logic       ovf [4];
   logic       unf [4];
   logic       amax [4];
   logic       amin [4];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         mx [4] = '{15, 9, 9, 1};
   int         sat [4] = '{0, 0, 1, 0};
   int         rv [4] = '{0, 3, 0, 0};
   int         wide [4] = '{0, 1, 1, 0};

   always #5 clk = ~clk;

   counter_mod_step #(.width_p(4)) u_a (
      .clk_i(clk), .reset_i(rst), .en_i(en), .up_i(up), .down_i(dn), .step_i(step[0:0]),
      .load_i(ld), .load_val_i(ldv), .count_o(cnt[0]), .ovf_o(ovf[0]), .unf_o(unf[0]),
      .at_max_o(amax[0]), .at_min_o(amin[0]));
   counter_mod_step #(.width_p(4), .max_val_p(9), .reset_val_p(3), .step_width_p(2), .saturate_p(1'b0)) u_w (
      .clk_i(clk), .reset_i(rst), .en_i(en), .up_i(up), .down_i(dn), .step_i(step),
      .load_i(ld), .load_val_i(ldv), .count_o(cnt[1]), .ovf_o(ovf[1]), .unf_o(unf[1]),
      .at_max_o(amax[1]), .at_min_o(amin[1]));
   counter_mod_step #(.width_p(4), .max_val_p(9), .reset_val_p(0), .step_width_p(2), .saturate_p(1'b1)) u_s (
      .clk_i(clk), .reset_i(rst), .en_i(en), .up_i(up), .down_i(dn), .step_i(step),
      .load_i(ld), .load_val_i(ldv), .count_o(cnt[2]), .ovf_o(ovf[2]), .unf_o(unf[2]),
      .at_max_o(amax[2]), .at_min_o(amin[2]));
   counter_mod_step #(.width_p(4), .max_val_p(1), .reset_val_p(0), .step_width_p(1), .saturate_p(1'b0)) u_m (
      .clk_i(clk), .reset_i(rst), .en_i(en), .up_i(up), .down_i(dn), .step_i(step[0:0]),
      .load_i(ld), .load_val_i(ldv), .count_o(cnt[3]), .ovf_o(ovf[3]), .unf_o(unf[3]),
      .at_max_o(amax[3]), .at_min_o(amin[3]));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1; en = 0; up = 0; dn = 0; ld = 0; ldv = 0; step = 0;
      tick();
      n_cmp++; if (cnt[0] !== 4'd0) begin n_bad++; $display("FAIL reset_a_count got %0d want 0", cnt[0]); end
      n_cmp++; if (amin[0] !== 1'b1) begin n_bad++; $display("FAIL reset_a_at_min got %b want 1", amin[0]); end
      n_cmp++; if (ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin n_bad++; $display("FAIL reset_a_pulses got %b%b want 00", ovf[0], unf[0]); end
      n_cmp++; if (cnt[1] !== 4'd3) begin n_bad++; $display("FAIL reset_w_count got %0d want 3", cnt[1]); end
      n_cmp++; if (cnt[2] !== 4'd0) begin n_bad++; $display("FAIL reset_s_count got %0d want 0", cnt[2]); end
      rst = 0;
   endtask

   task automatic test_up16;
      logic [3:0] e;
      en = 1; up = 1; dn = 0; step = 2'd1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         e = 4'(i % 16);
         n_cmp++; if (cnt[0] !== e) begin n_bad++; $display("FAIL up16_count[%0d] got %0d want %0d", i, cnt[0], e); end
         n_cmp++; if (ovf[0] !== (i == 16)) begin n_bad++; $display("FAIL up16_ovf[%0d] got %b want %b", i, ovf[0], i == 16); end
         n_cmp++; if (amax[0] !== (e == 4'd15)) begin n_bad++; $display("FAIL up16_at_max[%0d] got %b want %b", i, amax[0], e == 4'd15); end
      end
   endtask

   task automatic test_wrap_mod9;
      en = 1; up = 0; dn = 0; ld = 1; ldv = 4'd8;
      tick();
      n_cmp++; if (cnt[1] !== 4'd8) begin n_bad++; $display("FAIL wrap_load got %0d want 8", cnt[1]); end
      ld = 0; up = 1; step = 2'd3;
      tick();
      n_cmp++; if (cnt[1] !== 4'd1 || ovf[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_up got %0d/%b want 1/1", cnt[1], ovf[1]); end
      up = 0; dn = 1; step = 2'd2;
      tick();
      n_cmp++; if (cnt[1] !== 4'd9 || unf[1] !== 1'b1 || ovf[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_down got %0d/%b%b want 9/01", cnt[1], ovf[1], unf[1]); end
      n_cmp++; if (amax[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_at_max got %b want 1", amax[1]); end
      en = 0;
      tick();
      n_cmp++; if (cnt[1] !== 4'd9 || unf[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_pulse_end got %0d/%b want 9/0", cnt[1], unf[1]); end
   endtask

   task automatic test_saturate;
      en = 1; up = 0; dn = 0; ld = 1; ldv = 4'd7;
      tick();
      ld = 0; up = 1; step = 2'd3;
      tick();
      n_cmp++; if (cnt[2] !== 4'd9 || ovf[2] !== 1'b1) begin n_bad++; $display("FAIL sat_up got %0d/%b want 9/1", cnt[2], ovf[2]); end
      step = 2'd1;
      tick();
      n_cmp++; if (cnt[2] !== 4'd9 || ovf[2] !== 1'b1) begin n_bad++; $display("FAIL sat_up_at_max got %0d/%b want 9/1", cnt[2], ovf[2]); end
      ld = 1; ldv = 4'd1; up = 0;
      tick();
      n_cmp++; if (cnt[2] !== 4'd1 || ovf[2] !== 1'b0) begin n_bad++; $display("FAIL sat_load1 got %0d/%b want 1/0", cnt[2], ovf[2]); end
      ld = 0; dn = 1; step = 2'd3;
      tick();
      n_cmp++; if (cnt[2] !== 4'd0 || unf[2] !== 1'b1) begin n_bad++; $display("FAIL sat_down got %0d/%b want 0/1", cnt[2], unf[2]); end
      step = 2'd1;
      tick();
      n_cmp++; if (cnt[2] !== 4'd0 || unf[2] !== 1'b1) begin n_bad++; $display("FAIL sat_down_at_min got %0d/%b want 0/1", cnt[2], unf[2]); end
      en = 0;
      tick();
      n_cmp++; if (unf[2] !== 1'b0 || amin[2] !== 1'b1) begin n_bad++; $display("FAIL sat_idle got unf=%b at_min=%b want 0/1", unf[2], amin[2]); end
   endtask

   task automatic test_priority;
      en = 1; up = 1; dn = 0; step = 2'd1; ld = 1; ldv = 4'd12;
      tick();
      n_cmp++; if (cnt[2] !== 4'd9 || ovf[2] !== 1'b0) begin n_bad++; $display("FAIL prio_load_s got %0d/%b want 9/0", cnt[2], ovf[2]); end
      n_cmp++; if (cnt[1] !== 4'd9 || ovf[1] !== 1'b0) begin n_bad++; $display("FAIL prio_load_w got %0d/%b want 9/0", cnt[1], ovf[1]); end
      n_cmp++; if (cnt[3] !== 4'd1) begin n_bad++; $display("FAIL prio_load_m got %0d want 1", cnt[3]); end
      ld = 0; dn = 1;
      tick();
      n_cmp++; if (cnt[2] !== 4'd9 || ovf[2] !== 1'b0 || unf[2] !== 1'b0) begin n_bad++; $display("FAIL prio_updown got %0d/%b%b want 9/00", cnt[2], ovf[2], unf[2]); end
      dn = 0; en = 0;
      tick();
      n_cmp++; if (cnt[2] !== 4'd9 || ovf[2] !== 1'b0) begin n_bad++; $display("FAIL prio_disabled got %0d/%b want 9/0", cnt[2], ovf[2]); end
      en = 1; step = 2'd0;
      tick();
      n_cmp++; if (cnt[1] !== 4'd9 || ovf[1] !== 1'b0 || ovf[2] !== 1'b0) begin n_bad++; $display("FAIL prio_step0 got %0d/%b%b want 9/00", cnt[1], ovf[1], ovf[2]); end
   endtask

   task automatic test_reset_mid;
      en = 1; up = 0; dn = 0; ld = 1; ldv = 4'd5;
      tick();
      ld = 0; up = 1; step = 2'd1; rst = 1;
      tick();
      n_cmp++; if (cnt[1] !== 4'd3 || ovf[1] !== 1'b0 || unf[1] !== 1'b0) begin n_bad++; $display("FAIL rstmid_count got %0d/%b%b want 3/00", cnt[1], ovf[1], unf[1]); end
      rst = 0;
      tick();
      n_cmp++; if (cnt[1] !== 4'd4) begin n_bad++; $display("FAIL rstmid_resume got %0d want 4", cnt[1]); end
      ld = 1; ldv = 4'd9; up = 1;
      tick();
      ld = 0; rst = 1;
      tick();
      n_cmp++; if (cnt[2] !== 4'd0 || ovf[2] !== 1'b0) begin n_bad++; $display("FAIL rstmid_suppress got %0d/%b want 0/0", cnt[2], ovf[2]); end
      rst = 0;
   endtask

   task automatic test_random;
      int m [4];
      int eo [4];
      int eu [4];
      int s, t;
      rst = 1;
      tick();
      for (int k = 0; k < 4; k++) m[k] = rv[k];
      rst = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         ld = ($urandom_range(0, 9) == 0);
         en = ($urandom_range(0, 7) != 0);
         up = 1'($urandom);
         dn = 1'($urandom);
         step = 2'($urandom);
         ldv = 4'($urandom);
         for (int k = 0; k < 4; k++) begin
            s = wide[k] ? int'(step) : int'(step[0]);
            eo[k] = 0; eu[k] = 0;
            if (rst) m[k] = rv[k];
            else if (ld) m[k] = (int'(ldv) > mx[k]) ? mx[k] : int'(ldv);
            else if (en && (up != dn)) begin
               if (up) begin
                  t = m[k] + s;
                  if (t > mx[k]) begin eo[k] = 1; m[k] = sat[k] ? mx[k] : t - mx[k] - 1; end
                  else m[k] = t;
               end else begin
                  if (s > m[k]) begin eu[k] = 1; m[k] = sat[k] ? 0 : m[k] + mx[k] + 1 - s; end
                  else m[k] = m[k] - s;
               end
            end
         end
         tick();
         for (int k = 0; k < 4; k++) begin
            n_cmp++; if (cnt[k] !== 4'(m[k]) || int'(cnt[k]) > mx[k]) begin n_bad++; $display("FAIL rand_count[%0d] cyc %0d got %0d want %0d", k, c, cnt[k], m[k]); end
            n_cmp++; if (ovf[k] !== 1'(eo[k]) || unf[k] !== 1'(eu[k])) begin n_bad++; $display("FAIL rand_pulse[%0d] cyc %0d got %b%b want %0d%0d", k, c, ovf[k], unf[k], eo[k], eu[k]); end
            n_cmp++; if (amax[k] !== (m[k] == mx[k]) || amin[k] !== (m[k] == 0)) begin n_bad++; $display("FAIL rand_flags[%0d] cyc %0d got %b%b want %b%b", k, c, amax[k], amin[k], m[k] == mx[k], m[k] == 0); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_up16();
      test_wrap_mod9();
      test_saturate();
      test_priority();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
